lfsr_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 19 +
 rtl/sat_counter.sv | 23 ++
 rtl/lfsr_checker.sv | 129 ++++++++++++
 tb/tb_lfsr_checker.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, FSM states and tap-parity helper for the 8-bit LFSR pattern
// path: b[n+8] = b[n+4]^b[n+3]^b[n+2]^b[n], serial output is state bit 0.
package lfsr_pkg;

    localparam int          LFSR_W   = 8;
    localparam logic [7:0]  TAP_MASK = 8'b0001_1101;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Next stream bit given the last LFSR_W bits, h[0] oldest and h[LFSR_W-1] newest.
    function automatic logic lfsr_predict(input logic [LFSR_W-1:0] h);
        return ^(h & TAP_MASK);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that sticks at all-ones; clr wins over inc, rst_n wins over both.
// One cycle from inc/clr to cnt; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 8-bit LFSR test stream: seed, verify, then free-run and count errors.
// All outputs registered (visible after the edge sampling the bit); in_valid=0 stalls everything.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 16,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             sync_lost,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int SW = $clog2(LFSR_W);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);

    state_t              state;
    logic [LFSR_W-1:0]   hist;
    logic [SW-1:0]       seed_cnt;
    logic [GW-1:0]       good_cnt;
    logic [BW-1:0]       bad_cnt;

    logic                pred;
    logic                mismatch;
    logic [LFSR_W-1:0]   hist_rx;
    logic                err_inc;
    logic                bit_inc;

    assign pred     = lfsr_predict(hist);
    assign mismatch = (in_bit != pred);
    assign hist_rx  = {in_bit, hist[LFSR_W-1:1]};
    assign bit_inc  = in_valid && (state == LOCKED);
    assign err_inc  = bit_inc && mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SEED;
            hist      <= '0;
            seed_cnt  <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            sync_lost <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            sync_lost <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEED: begin
                        hist <= hist_rx;
                        if (seed_cnt == SW'(LFSR_W - 1)) begin
                            seed_cnt <= '0;
                            // An all-zero seed would predict zeros forever; keep seeding instead.
                            if (hist_rx != '0) begin
                                state    <= VERIFY;
                                good_cnt <= '0;
                            end
                        end else begin
                            seed_cnt <= seed_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        hist <= hist_rx;
                        if (!mismatch) begin
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            state    <= SEED;
                            seed_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Shift in the prediction so corrupted received bits never poison the reference.
                        hist <= {pred, hist[LFSR_W-1:1]};
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (bad_cnt == BW'(LOSS_CNT - 1)) begin
                                state     <= SEED;
                                seed_cnt  <= '0;
                                bad_cnt   <= '0;
                                locked    <= 1'b0;
                                sync_lost <= 1'b1;
                            end else begin
                                bad_cnt <= bad_cnt + 1'b1;
                            end
                        end else begin
                            bad_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= SEED;
                        seed_cnt <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .clr   (clr),
        .cnt   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bit_inc),
        .clr   (clr),
        .cnt   (bit_cnt)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stream-level reference model feeds an expectation queue
// popped by an independent monitor, plus directed end-of-scenario checks.
module tb_lfsr_checker;
    import lfsr_pkg::*;

    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;
    localparam int CNT_W    = 7;
    localparam int MAXC     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             locked;
        logic             err_pulse;
        logic             sync_lost;
        logic [CNT_W-1:0] err_cnt;
        logic [CNT_W-1:0] bit_cnt;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic             sync_lost;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] bit_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    obs_t sb[$];

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .sync_lost (sync_lost),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the recent stream as a bit queue, prediction via stream recurrence.
    bit ref_bits[$];
    int m_mode;   // 0 seeding, 1 verifying, 2 locked
    int m_seed_n, m_good_n, m_bad_n, m_err, m_bit;
    bit m_locked, m_errp, m_syncl;

    function automatic bit ref_next();
        int n = ref_bits.size();
        return ref_bits[n-4] ^ ref_bits[n-5] ^ ref_bits[n-6] ^ ref_bits[n-8];
    endfunction

    function automatic void ref_push(input bit b);
        ref_bits.push_back(b);
        if (ref_bits.size() > LFSR_W) void'(ref_bits.pop_front());
    endfunction

    function automatic void model_step(input bit r, input bit v, input bit b, input bit c);
        bit p;
        bit all_zero;
        m_errp  = 1'b0;
        m_syncl = 1'b0;
        if (!r) begin
            ref_bits.delete();
            for (int i = 0; i < LFSR_W; i++) ref_bits.push_back(1'b0);
            m_mode = 0; m_seed_n = 0; m_good_n = 0; m_bad_n = 0;
            m_err = 0; m_bit = 0; m_locked = 1'b0;
            return;
        end
        if (v) begin
            p = ref_next();
            if (m_mode == 0) begin
                ref_push(b);
                m_seed_n++;
                if (m_seed_n == LFSR_W) begin
                    m_seed_n = 0;
                    all_zero = 1'b1;
                    foreach (ref_bits[i]) if (ref_bits[i]) all_zero = 1'b0;
                    if (!all_zero) begin
                        m_mode = 1;
                        m_good_n = 0;
                    end
                end
            end else if (m_mode == 1) begin
                ref_push(b);
                if (b == p) begin
                    m_good_n++;
                    if (m_good_n == LOCK_CNT) begin
                        m_mode = 2;
                        m_locked = 1'b1;
                    end
                end else begin
                    m_mode = 0;
                    m_seed_n = 0;
                end
            end else begin
                ref_push(p);
                if (m_bit < MAXC) m_bit++;
                if (b != p) begin
                    m_errp = 1'b1;
                    if (m_err < MAXC) m_err++;
                    m_bad_n++;
                    if (m_bad_n == LOSS_CNT) begin
                        m_mode = 0; m_seed_n = 0; m_bad_n = 0;
                        m_syncl = 1'b1; m_locked = 1'b0;
                    end
                end else begin
                    m_bad_n = 0;
                end
            end
        end
        if (c) begin
            m_err = 0;
            m_bit = 0;
        end
    endfunction

    task automatic drive(input bit v, input bit b, input bit c, input bit r);
        obs_t e;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clr      = c;
        rst_n    = r;
        model_step(r, v, b, c);
        e.locked    = m_locked;
        e.err_pulse = m_errp;
        e.sync_lost = m_syncl;
        e.err_cnt   = CNT_W'(m_err);
        e.bit_cnt   = CNT_W'(m_bit);
        sb.push_back(e);
    endtask

    // Monitor: every edge that sampled a driven cycle has an expectation waiting.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                a = '{locked, err_pulse, sync_lost, err_cnt, bit_cnt};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got lk=%b ep=%b sl=%b err=%0d bit=%0d, want lk=%b ep=%b sl=%b err=%0d bit=%0d",
                             $time, a.locked, a.err_pulse, a.sync_lost, a.err_cnt, a.bit_cnt,
                             e.locked, e.err_pulse, e.sync_lost, e.err_cnt, e.bit_cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    logic [LFSR_W-1:0] gen;
    int bitno;

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        bitno = 0;
    endtask

    // Sends n generator bits, inverting stream bits inv_lo..inv_hi (1-based), optional idle gaps.
    task automatic send_bits(input int n, input int inv_lo, input int inv_hi, input bit gaps);
        bit b;
        for (int i = 0; i < n; i++) begin
            bitno++;
            b   = gen[0];
            gen = {lfsr_predict(gen), gen[LFSR_W-1:1]};
            if (bitno >= inv_lo && bitno <= inv_hi) b = ~b;
            drive(1'b1, b, 1'b0, 1'b1);
            if (gaps) drive(1'b0, 1'($urandom), 1'b0, 1'b1);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        settle();
        chk("reset_locked", locked, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_bit_cnt", bit_cnt, 0);

        // All-zero stream never leaves seeding
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("zeros_locked", locked, 0);
        chk("zeros_bit_cnt", bit_cnt, 0);

        // Clean stream: lock exactly after bit 24, 76 bits checked by bit 100
        do_reset();
        gen = 8'hA5;
        send_bits(23, 0, -1, 1'b0);
        settle();
        chk("clean_locked_bit23", locked, 0);
        send_bits(1, 0, -1, 1'b0);
        settle();
        chk("clean_locked_bit24", locked, 1);
        send_bits(76, 0, -1, 1'b0);
        settle();
        chk("clean_bit_cnt", bit_cnt, 76);
        chk("clean_err_cnt", err_cnt, 0);

        // Single flipped bit
        do_reset();
        gen = 8'hA5;
        send_bits(40, 40, 40, 1'b0);
        settle();
        chk("flip1_err_pulse", err_pulse, 1);
        send_bits(60, 40, 40, 1'b0);
        settle();
        chk("flip1_err_cnt", err_cnt, 1);
        chk("flip1_locked", locked, 1);
        chk("flip1_bit_cnt", bit_cnt, 76);

        // Four flipped bits drop lock; relock 24 bits later
        do_reset();
        gen = 8'hA5;
        send_bits(43, 40, 43, 1'b0);
        settle();
        chk("loss_sync_lost", sync_lost, 1);
        chk("loss_err_pulse", err_pulse, 1);
        chk("loss_locked", locked, 0);
        chk("loss_err_cnt", err_cnt, 4);
        send_bits(23, 40, 43, 1'b0);
        settle();
        chk("relock_early", locked, 0);
        send_bits(1, 40, 43, 1'b0);
        settle();
        chk("relock_locked", locked, 1);
        chk("relock_err_cnt", err_cnt, 4);

        // Gapped valid gives the same counts in valid-bit terms
        do_reset();
        gen = 8'hA5;
        send_bits(100, 0, -1, 1'b1);
        settle();
        chk("gap_bit_cnt", bit_cnt, 76);
        chk("gap_locked", locked, 1);

        // clr with a simultaneous error, then reset mid-lock
        do_reset();
        gen = 8'h5C;
        send_bits(30, 0, -1, 1'b0);
        bitno++;
        drive(1'b1, ~gen[0], 1'b1, 1'b1);
        gen = {lfsr_predict(gen), gen[LFSR_W-1:1]};
        settle();
        chk("clr_err_pulse", err_pulse, 1);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_bit_cnt", bit_cnt, 0);
        drive(1'b1, gen[0], 1'b0, 1'b0);
        settle();
        chk("midrst_locked", locked, 0);
        chk("midrst_bit_cnt", bit_cnt, 0);
        bitno = 0;
        send_bits(23, 0, -1, 1'b0);
        settle();
        chk("midrst_relock_early", locked, 0);
        send_bits(1, 0, -1, 1'b0);
        settle();
        chk("midrst_relock", locked, 1);

        // Saturation of bit_cnt
        do_reset();
        gen = 8'hA5;
        send_bits(24 + MAXC + 20, 0, -1, 1'b0);
        settle();
        chk("sat_bit_cnt", bit_cnt, MAXC);

        // Randomised traffic: gaps, bit errors, clears, occasional reset
        do_reset();
        gen = 8'(($urandom_range(1, 255)));
        for (int i = 0; i < 1500; i++) begin
            bit v, b, c, r;
            r = ($urandom_range(0, 399) != 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            b = 1'($urandom);
            if (v) begin
                b   = gen[0] ^ ($urandom_range(0, 29) == 0);
                gen = {lfsr_predict(gen), gen[LFSR_W-1:1]};
            end
            drive(v, b, c, r);
        end

        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
